findmax_controller: RTL
=======================

Name: findmax_controller

Overview:
Sequencer for the find-max datapath. It accepts a start command with a start address and element count, and streams one memory read per cycle through the block RAM port. It absorbs the RAM read latency and tracks the running unsigned maximum and the address where it was found. It then reports completion through a single-cycle done pulse, and replaces the ad-hoc enable/done coupling between the FSM, the address counter and the comparator.

Parameters:
ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 16, memory data and max width
CNT_W, 8, width of element count N
RD_LAT, 1, memory read latency in cycles, from mem_en/mem_addr to valid douta (legal 1..4)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  command strobe; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE without done
startAddr  in  ADDR_W  first address to scan; captured on accepted start
N  in  CNT_W  number of elements to scan; captured on accepted start
douta  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en
mem_en  out  1  memory read enable, one per issued address
addr  out  ADDR_W  memory read address
busy  out  1  high from the cycle after an accepted start until done/abort
done  out  1  one-cycle pulse when the result is final
max  out  DATA_W  largest value seen; held until the next accepted start
max_addr  out  ADDR_W  address of max (first occurrence)
count  out  CNT_W  number of elements compared so far

Behaviour:
- Reset (reset=0, async): state=IDLE; mem_en=0, addr=0, busy=0, done=0, max=0, max_addr=0, count=0; valid pipeline cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 captures startAddr and N, and clears max, max_addr and count.
  - If N!=0, go to ISSUE; if N==0, go to DONE.
  - start while not IDLE is ignored, with no queuing.
- ISSUE:
  - mem_en=1 every cycle; addr = captured base + issue index, truncated to ADDR_W, so addresses wrap from 2^ADDR_W-1 to 0.
  - Issue counter runs 0..N-1; after the N-th issue, go to DRAIN.
- Valid tracking:
  - A shift register of depth RD_LAT carries mem_en and the issued address alongside.
  - When its output is 1, douta is a valid sample for that address.
- Compare on each valid sample:
  - First sample (count==0): load max=douta and max_addr=its address unconditionally.
  - Later samples: update only if douta > max, unsigned strict, so ties keep the earlier address.
  - count increments by 1 on every valid sample.
- DRAIN: mem_en=0; when count reaches N, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then go to IDLE.
  - max, max_addr and count hold until the next accepted start.
  - For N==0: done pulses with max=0, max_addr=0, count=0.
- Latency: start accepted at cycle 0, first mem_en at cycle 1, last mem_en at cycle N, last valid data at cycle N+RD_LAT. done is high during cycle N+RD_LAT+1. Throughput is one element per clock.
- busy is high in ISSUE and DRAIN.
- abort:
  - Effective in any non-IDLE state; next state is IDLE, mem_en drops immediately, the valid pipeline is flushed, and done is never raised.
  - max and count keep their partial values.
  - abort and start in the same IDLE cycle: abort has priority and start is dropped.
- N=2^CNT_W-1 must complete without counter overflow; internal counters are CNT_W bits, compared for equality with the captured N.
- Reset asserted mid-scan returns immediately to reset values; no done is produced.

Test Plan:
1. Memory holds {3,9,2,9,5} at 0x10..0x14; start with startAddr=0x10, N=5, RD_LAT=1 -> addr 0x10..0x14 on cycles 1..5; done on cycle 7 with max=9, max_addr=0x11, count=5.
2. N=0, start -> done pulses on cycle 1 (the DONE cycle after acceptance), max=0, max_addr=0, count=0, mem_en never high.
3. Wrap: startAddr=0xFE, N=4, values {1,2,0xFFFF,4} -> addr sequence FE,FF,00,01; max=0xFFFF, max_addr=0x00.
4. RD_LAT=3, N=3, values {7,8,6} -> done exactly at cycle N+RD_LAT+1=7; max=8; a start pulse on cycle 2 is ignored.
5. abort on cycle 3 of an N=10 scan -> mem_en low on cycle 4, busy low, no done pulse; a fresh start then completes normally.
6. reset driven low asynchronously mid-ISSUE (between clock edges) -> all outputs at reset values before the next edge; with N=255 over all-0x0001 data followed by 0x8000 at the last address, max=0x8000 and count=255.

Source files
------------

// File: rtl/findmax_controller.sv
// findmax_controller: streams N memory reads from a start address and tracks the unsigned maximum
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-low reset
//   start, abort    - command strobe (IDLE only) and synchronous cancel (abort wins)
//   startAddr, N    - scan base address and element count, captured on an accepted start
//   douta           - memory read data, valid RD_LAT cycles after mem_en
//   mem_en, addr    - memory read port, one address per cycle while issuing
//   busy, done      - busy while issuing/draining, done is a one-cycle completion pulse
//   max, max_addr   - running maximum and the address of its first occurrence
//   count           - number of samples compared so far
module findmax_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [CNT_W-1:0]  N,
  input  logic [DATA_W-1:0] douta,
  output logic              mem_en,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max,
  output logic [ADDR_W-1:0] max_addr,
  output logic [CNT_W-1:0]  count
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  n_q, iss_q, cnt_q, cnt_d;
  logic [DATA_W-1:0] max_q;
  logic [ADDR_W-1:0] maxa_q;
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] va_q [RD_LAT];
  logic              accept, last_iss, smp;
  assign accept   = state_q == IDLE && start && !abort;
  assign last_iss = iss_q == n_q - CNT_W'(1);
  // a sample arriving in the abort cycle belongs to the flushed pipeline and is discarded
  assign smp      = vld_q[RD_LAT-1] && !abort;
  assign cnt_d    = cnt_q + CNT_W'(smp);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  // DRAIN looks at the post-increment count so done follows the last sample by one cycle
  always_comb
    state_d = abort              ? IDLE :
              state_q == IDLE    ? (start ? (N == '0 ? DONE : ISSUE) : IDLE) :
              state_q == ISSUE   ? (last_iss ? DRAIN : ISSUE) :
              state_q == DRAIN   ? (cnt_d == n_q ? DONE : DRAIN) : IDLE;
  always_comb begin
    mem_en = state_q == ISSUE;
    busy   = state_q == ISSUE || state_q == DRAIN;
    done   = state_q == DONE;
    addr   = base_q + ADDR_W'(iss_q);
  end
  // the read-valid pipeline carries each issued address so the compare knows where douta came from
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      base_q <= '0;
      n_q    <= '0;
      iss_q  <= '0;
      cnt_q  <= '0;
      max_q  <= '0;
      maxa_q <= '0;
      vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) va_q[i] <= '0;
    end else begin
      iss_q    <= accept ? '0 : mem_en ? iss_q + CNT_W'(1) : iss_q;
      vld_q[0] <= mem_en && !abort;
      va_q[0]  <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1] && !abort;
        va_q[i]  <= va_q[i-1];
      end
      if (accept) begin
        base_q <= startAddr;
        n_q    <= N;
        cnt_q  <= '0;
        max_q  <= '0;
        maxa_q <= '0;
      end else if (smp) begin
        cnt_q <= cnt_d;
        if (cnt_q == '0 || douta > max_q) begin
          max_q  <= douta;
          maxa_q <= va_q[RD_LAT-1];
        end
      end
    end
  assign max      = max_q;
  assign max_addr = maxa_q;
  assign count    = cnt_q;
endmodule
